// File: rtl/wb_select_stage.sv
// rtl/wb_select_stage.sv - MEM/WB register with four-source writeback mux and load extraction
module wb_select_stage #(
  parameter int XLEN        = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int ZERO_REG_WE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [1:0]            wb_sel,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [XLEN-1:0]       mem_data,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [XLEN-1:0]       pc_plus4,
  input  logic [XLEN-1:0]       imm,
  input  logic [2:0]            funct3,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic                  load_misaligned
);

  logic [1:0]      offset;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] sel_data;
  logic            load_ok;
  logic            misaligned;
  logic            is_load;
  logic            we_next;
  logic            mis_next;

  always_comb begin
    offset     = alu_result[1:0];
    lane       = mem_data >> {offset, 3'b000};
    load_data  = '0;
    load_ok    = 1'b1;
    misaligned = 1'b0;
    case (funct3)
      3'b000: load_data = XLEN'($signed(lane[7:0]));
      3'b100: load_data = XLEN'(lane[7:0]);
      3'b001: begin
        load_data  = XLEN'($signed(lane[15:0]));
        misaligned = offset[0];
      end
      3'b101: begin
        load_data  = XLEN'(lane[15:0]);
        misaligned = offset[0];
      end
      3'b010: begin
        load_data  = XLEN'($signed(mem_data[31:0]));
        misaligned = (offset != 2'b00);
      end
      default: load_ok = 1'b0;
    endcase
  end

  always_comb begin
    is_load  = (wb_sel == 2'd0);
    sel_data = '0;
    case (wb_sel)
      2'd0:    sel_data = load_ok ? load_data : '0;
      2'd1:    sel_data = alu_result;
      2'd2:    sel_data = pc_plus4;
      default: sel_data = imm;
    endcase
    // Bad or misaligned loads must never reach the register file.
    we_next  = in_valid && reg_write
               && ((ZERO_REG_WE != 0) || (rd_in != '0))
               && !(is_load && (!load_ok || misaligned));
    mis_next = in_valid && is_load && misaligned;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid        <= 1'b0;
      wb_we           <= 1'b0;
      wb_rd           <= '0;
      wb_data         <= '0;
      load_misaligned <= 1'b0;
    end else if (!stall) begin
      wb_rd   <= rd_in;
      wb_data <= sel_data;
      if (flush) begin
        wb_valid        <= 1'b0;
        wb_we           <= 1'b0;
        load_misaligned <= 1'b0;
      end else begin
        wb_valid        <= in_valid;
        wb_we           <= we_next;
        load_misaligned <= mis_next;
      end
    end
  end

endmodule

// File: tb/tb_wb_select_stage.sv
// tb/tb_wb_select_stage.sv - directed self-checking bench for wb_select_stage
module tb_wb_select_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, stall, flush, reg_write;
  logic [1:0]  wb_sel;
  logic [4:0]  rd_in;
  logic [31:0] mem_data, alu_result, pc_plus4, imm;
  logic [2:0]  funct3;
  logic        wb_valid, wb_we, load_misaligned;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_cmp = 0;
  int n_err = 0;

  wb_select_stage #(.XLEN(32), .REG_ADDR_W(5), .ZERO_REG_WE(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .wb_sel(wb_sel), .reg_write(reg_write), .rd_in(rd_in), .mem_data(mem_data),
    .alu_result(alu_result), .pc_plus4(pc_plus4), .imm(imm), .funct3(funct3),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .load_misaligned(load_misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic rw, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [2:0] f3);
    in_valid   = v;
    wb_sel     = sel;
    reg_write  = rw;
    rd_in      = rd;
    alu_result = alu;
    funct3     = f3;
  endtask

  task automatic check_all(input string tag, input logic v, input logic we, input logic [4:0] rd,
                           input logic [31:0] data, input logic mis);
    check({tag, ".valid"}, 32'(wb_valid), 32'(v));
    check({tag, ".we"}, 32'(wb_we), 32'(we));
    check({tag, ".rd"}, 32'(wb_rd), 32'(rd));
    check({tag, ".data"}, wb_data, data);
    check({tag, ".mis"}, 32'(load_misaligned), 32'(mis));
  endtask

  initial begin
    rst_n = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    mem_data = 32'h80F1_7F82;
    pc_plus4 = 32'h0000_0104;
    imm      = 32'h1234_5000;
    drive(1'b1, 2'd1, 1'b1, 5'd3, 32'h0000_00AA, 3'b010);
    #3 rst_n = 1'b0;
    #1;
    check_all("reset", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    step();
    check_all("reset_held", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    rst_n = 1'b1;

    drive(1'b1, 2'd1, 1'b1, 5'd5, 32'h0000_0020, 3'b000);
    step();
    check_all("alu", 1'b1, 1'b1, 5'd5, 32'h0000_0020, 1'b0);

    drive(1'b1, 2'd0, 1'b1, 5'd6, 32'h0000_1000, 3'b000);
    step();
    check_all("lb_off0", 1'b1, 1'b1, 5'd6, 32'hFFFF_FF82, 1'b0);
    drive(1'b1, 2'd0, 1'b1, 5'd6, 32'h0000_1003, 3'b100);
    step();
    check_all("lbu_off3", 1'b1, 1'b1, 5'd6, 32'h0000_0080, 1'b0);
    drive(1'b1, 2'd0, 1'b1, 5'd6, 32'h0000_1002, 3'b001);
    step();
    check_all("lh_off2", 1'b1, 1'b1, 5'd6, 32'hFFFF_80F1, 1'b0);
    drive(1'b1, 2'd0, 1'b1, 5'd6, 32'h0000_1000, 3'b101);
    step();
    check_all("lhu_off0", 1'b1, 1'b1, 5'd6, 32'h0000_7F82, 1'b0);
    drive(1'b1, 2'd0, 1'b1, 5'd6, 32'h0000_1001, 3'b100);
    step();
    check_all("lbu_off1", 1'b1, 1'b1, 5'd6, 32'h0000_007F, 1'b0);
    drive(1'b1, 2'd0, 1'b1, 5'd6, 32'h0000_1000, 3'b010);
    step();
    check_all("lw_aligned", 1'b1, 1'b1, 5'd6, 32'h80F1_7F82, 1'b0);

    drive(1'b1, 2'd0, 1'b1, 5'd6, 32'h0000_1002, 3'b010);
    step();
    check("lw_mis.mis", 32'(load_misaligned), 32'd1);
    check("lw_mis.we", 32'(wb_we), 32'd0);
    check("lw_mis.valid", 32'(wb_valid), 32'd1);
    drive(1'b1, 2'd0, 1'b1, 5'd6, 32'h0000_1003, 3'b101);
    step();
    check("lhu_odd.mis", 32'(load_misaligned), 32'd1);
    check("lhu_odd.we", 32'(wb_we), 32'd0);
    drive(1'b0, 2'd0, 1'b1, 5'd6, 32'h0000_1002, 3'b010);
    step();
    check("mis_novalid.mis", 32'(load_misaligned), 32'd0);
    check("mis_novalid.valid", 32'(wb_valid), 32'd0);

    drive(1'b1, 2'd0, 1'b1, 5'd6, 32'h0000_1000, 3'b011);
    step();
    check_all("reserved", 1'b1, 1'b0, 5'd6, 32'h0, 1'b0);

    drive(1'b1, 2'd1, 1'b1, 5'd8, 32'h0000_1002, 3'b010);
    step();
    check_all("alu_ignores_f3", 1'b1, 1'b1, 5'd8, 32'h0000_1002, 1'b0);

    drive(1'b1, 2'd2, 1'b1, 5'd1, 32'h0000_0000, 3'b000);
    step();
    check_all("jal", 1'b1, 1'b1, 5'd1, 32'h0000_0104, 1'b0);

    drive(1'b1, 2'd1, 1'b1, 5'd0, 32'h0000_0033, 3'b000);
    step();
    check_all("rd0", 1'b1, 1'b0, 5'd0, 32'h0000_0033, 1'b0);

    drive(1'b1, 2'd1, 1'b0, 5'd4, 32'h0000_0044, 3'b000);
    step();
    check_all("no_regwrite", 1'b1, 1'b0, 5'd4, 32'h0000_0044, 1'b0);

    drive(1'b1, 2'd3, 1'b1, 5'd7, 32'h0000_0000, 3'b000);
    step();
    check_all("lui", 1'b1, 1'b1, 5'd7, 32'h1234_5000, 1'b0);

    stall = 1'b1;
    drive(1'b1, 2'd1, 1'b1, 5'd9, 32'h0000_DEAD, 3'b000);
    step();
    check_all("stall", 1'b1, 1'b1, 5'd7, 32'h1234_5000, 1'b0);
    flush = 1'b1;
    step();
    check_all("stall_flush", 1'b1, 1'b1, 5'd7, 32'h1234_5000, 1'b0);
    stall = 1'b0;
    drive(1'b1, 2'd1, 1'b1, 5'd10, 32'h0000_0055, 3'b000);
    step();
    check_all("flush", 1'b0, 1'b0, 5'd10, 32'h0000_0055, 1'b0);
    flush = 1'b0;
    drive(1'b1, 2'd1, 1'b1, 5'd11, 32'h0000_0077, 3'b000);
    step();
    check_all("resume", 1'b1, 1'b1, 5'd11, 32'h0000_0077, 1'b0);

    flush = 1'b1;
    drive(1'b1, 2'd0, 1'b1, 5'd6, 32'h0000_1002, 3'b010);
    step();
    check("flush_mis.mis", 32'(load_misaligned), 32'd0);
    check("flush_mis.valid", 32'(wb_valid), 32'd0);
    flush = 1'b0;

    drive(1'b1, 2'd1, 1'b1, 5'd12, 32'h0000_0099, 3'b000);
    step();
    check_all("pre_reset", 1'b1, 1'b1, 5'd12, 32'h0000_0099, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_reset", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    rst_n = 1'b1;
    drive(1'b1, 2'd1, 1'b1, 5'd13, 32'h0000_00C3, 3'b000);
    step();
    check_all("post_reset", 1'b1, 1'b1, 5'd13, 32'h0000_00C3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_select_stage.md
Name: wb_select_stage

Overview:
- Parametrised successor of the two-input memory/ALU writeback select. Merges the MEM/WB pipeline register with a four-source writeback mux.
- Load data is byte/halfword extracted and sign- or zero-extended, and misaligned loads are flagged.
- Sits between the data memory/ALU outputs and the register file write port. Also drives the WB forwarding path back to EX.

Parameters:
- XLEN, 32, datapath width in bits (32 or 64).
- REG_ADDR_W, 5, register-file address width.
- ZERO_REG_WE, 0, 1 allows writes to x0; 0 forces wb_we low whenever rd is 0.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  MEM stage holds a valid instruction
- stall  input  1  hold the WB register (hazard unit)
- flush  input  1  kill the instruction being captured
- wb_sel  input  2  source: 0 = memory, 1 = ALU, 2 = PC+4, 3 = immediate
- reg_write  input  1  instruction writes rd
- rd_in  input  REG_ADDR_W  destination register
- mem_data  input  XLEN  raw data-memory word
- alu_result  input  XLEN  ALU output; also the load byte address
- pc_plus4  input  XLEN  link value for JAL/JALR
- imm  input  XLEN  U-type immediate for LUI
- funct3  input  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- wb_valid  output  1  registered instruction is valid
- wb_we  output  1  register-file write enable
- wb_rd  output  REG_ADDR_W  register-file write address
- wb_data  output  XLEN  register-file write data
- load_misaligned  output  1  registered misaligned-load flag

Behaviour:
- All outputs are registered.
- Reset (rst_n = 0, asynchronous): wb_valid = 0, wb_we = 0, wb_rd = 0, wb_data = 0, load_misaligned = 0. Applies immediately, mid-operation included. The first capture happens on the first rising edge after rst_n deasserts.
- Latency: one cycle from input to outputs.
- Priority on each edge: reset > stall > flush > capture.
  - stall = 1: all outputs hold their values. This includes wb_we, so a held write re-asserts and is idempotent.
  - flush = 1 and stall = 0: wb_valid = 0, wb_we = 0, load_misaligned = 0. wb_rd and wb_data are still captured as normal; they are don't-care for the register file.
  - Otherwise: capture.
- Capture:
  - wb_valid = in_valid.
  - wb_we = in_valid & reg_write & (ZERO_REG_WE | (rd_in != 0)).
  - wb_rd = rd_in.
  - wb_data = selected value.
- Load extraction when wb_sel = 0. Byte offset is alu_result[1:0]; lane = mem_data shifted right by 8*offset.
  - LB / LBU: lane[7:0], sign- or zero-extended to XLEN.
  - LH / LHU: lane[15:0], extended likewise.
  - LW: mem_data[31:0]; sign-extended when XLEN = 64.
  - Reserved funct3 values: data = 0 and wb_we forced to 0.
- Misaligned load: asserted when wb_sel = 0 with an LH/LHU at an odd offset, or an LW at a nonzero offset.
  - load_misaligned = 1 and wb_we = 0; wb_data = extraction of the aligned word.
  - Qualified by in_valid; cleared by flush.
- For wb_sel 1, 2 and 3, funct3 and alignment are ignored. Values pass straight through, truncated or zero-extended to XLEN.
- No combinational path from any input to any output.

Test Plan:
- Reset: rst_n low mid-stream with wb_we = 1 -> all outputs 0 immediately, without waiting for a clock edge.
- ALU source: in_valid = 1, reg_write = 1, rd_in = 5, wb_sel = 1, alu_result = 0x20 -> next cycle wb_we = 1, wb_rd = 5, wb_data = 0x00000020.
- Load extraction: mem_data = 0x80F1_7F82; LB at offset 0 -> 0xFFFFFF82; LBU at offset 3 -> 0x00000080; LH at offset 2 -> 0xFFFF80F1; LHU at offset 0 -> 0x00007F82.
- Misaligned load: LW with alu_result = 0x1002 -> load_misaligned = 1, wb_we = 0.
- JAL link: wb_sel = 2, pc_plus4 = 0x104, rd = 1 -> wb_data = 0x104, wb_we = 1.
- LUI: wb_sel = 3, imm = 0x12345000 -> wb_data = 0x12345000.
- rd = 0 with ZERO_REG_WE = 0 -> wb_we = 0 while wb_valid = 1.
- Stall and flush, two cycles:
  - stall = 1 with new inputs -> outputs unchanged.
  - stall = 1 with flush = 1 -> still held.
  - stall = 0 with flush = 1 -> wb_valid = 0, wb_we = 0.
  - Next clean capture -> normal outputs resume.
